// File: rtl/tl_xbar_arb_nto1.sv
// TileLink-UL N:1 crossbar. Round-robin A-channel arbitration with burst locking;
// D-channel routed back to the client selected by the prepended source-index bits.
module tl_xbar_arb_nto1 #(
   parameter int unsigned N_IN   = 2,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned SRC_W  = 4,
   parameter int unsigned SIZE_W = 3,
   localparam int unsigned IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1,
   localparam int unsigned MASK_W = DATA_W / 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   // Client A channels
   input  logic [N_IN-1:0]            in_a_valid_i,
   output logic [N_IN-1:0]            in_a_ready_o,
   input  logic [3*N_IN-1:0]          in_a_opcode_i,
   input  logic [3*N_IN-1:0]          in_a_param_i,
   input  logic [SIZE_W*N_IN-1:0]     in_a_size_i,
   input  logic [SRC_W*N_IN-1:0]      in_a_source_i,
   input  logic [ADDR_W*N_IN-1:0]     in_a_address_i,
   input  logic [MASK_W*N_IN-1:0]     in_a_mask_i,
   input  logic [DATA_W*N_IN-1:0]     in_a_data_i,
   input  logic [N_IN-1:0]            in_a_corrupt_i,
   // Manager A channel
   output logic                       out_a_valid_o,
   input  logic                       out_a_ready_i,
   output logic [2:0]                 out_a_opcode_o,
   output logic [2:0]                 out_a_param_o,
   output logic [SIZE_W-1:0]          out_a_size_o,
   output logic [SRC_W+IDX_W-1:0]     out_a_source_o,
   output logic [ADDR_W-1:0]          out_a_address_o,
   output logic [MASK_W-1:0]          out_a_mask_o,
   output logic [DATA_W-1:0]          out_a_data_o,
   output logic                       out_a_corrupt_o,
   // Manager D channel
   input  logic                       out_d_valid_i,
   output logic                       out_d_ready_o,
   input  logic [2:0]                 out_d_opcode_i,
   input  logic [1:0]                 out_d_param_i,
   input  logic [SIZE_W-1:0]          out_d_size_i,
   input  logic [SRC_W+IDX_W-1:0]     out_d_source_i,
   input  logic                       out_d_sink_i,
   input  logic                       out_d_denied_i,
   input  logic [DATA_W-1:0]          out_d_data_i,
   input  logic                       out_d_corrupt_i,
   // Client D channels
   output logic [N_IN-1:0]            in_d_valid_o,
   input  logic [N_IN-1:0]            in_d_ready_i,
   output logic [3*N_IN-1:0]          in_d_opcode_o,
   output logic [2*N_IN-1:0]          in_d_param_o,
   output logic [SIZE_W*N_IN-1:0]     in_d_size_o,
   output logic [SRC_W*N_IN-1:0]      in_d_source_o,
   output logic [N_IN-1:0]            in_d_sink_o,
   output logic [N_IN-1:0]            in_d_denied_o,
   output logic [DATA_W*N_IN-1:0]     in_d_data_o,
   output logic [N_IN-1:0]            in_d_corrupt_o
);

   localparam int unsigned LOG_BYTES = $clog2(MASK_W);

   typedef enum logic [0:0] {StIdle, StLocked} state_e;

   state_e            state_q;
   logic [IDX_W-1:0]  last_grant_q;
   logic [IDX_W-1:0]  grant_idx_q;
   logic [SIZE_W:0]   beat_cnt_q;

   logic [IDX_W-1:0]  win_idx;
   logic              win_found;
   logic [IDX_W:0]    cand;
   logic [IDX_W-1:0]  act_idx;
   logic              act_valid;
   logic              a_fire;
   logic [SRC_W-1:0]  a_src_sel;
   logic [SIZE_W:0]   first_beats_m1;
   logic [IDX_W-1:0]  d_sel;
   logic              d_sel_ok;

   // Round-robin search starting one past the last granted client, wrapping at N_IN.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= int'(N_IN); k++) begin
         cand = {1'b0, last_grant_q} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(N_IN)) begin
            cand = cand - (IDX_W+1)'(N_IN);
         end
         if (!win_found && in_a_valid_i[cand[IDX_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IDX_W-1:0];
         end
      end
   end

   // While locked only the burst owner is routed, regardless of other requests.
   always_comb begin
      if (state_q == StLocked) begin
         act_idx   = grant_idx_q;
         act_valid = in_a_valid_i[grant_idx_q];
      end else begin
         act_idx   = win_idx;
         act_valid = win_found;
      end
   end

   // A payload mux and per-client ready steering.
   always_comb begin
      out_a_opcode_o  = '0;
      out_a_param_o   = '0;
      out_a_size_o    = '0;
      a_src_sel       = '0;
      out_a_address_o = '0;
      out_a_mask_o    = '0;
      out_a_data_o    = '0;
      out_a_corrupt_o = 1'b0;
      in_a_ready_o    = '0;
      for (int i = 0; i < int'(N_IN); i++) begin
         if (act_idx == IDX_W'(i)) begin
            out_a_opcode_o  = in_a_opcode_i[3*i +: 3];
            out_a_param_o   = in_a_param_i[3*i +: 3];
            out_a_size_o    = in_a_size_i[SIZE_W*i +: SIZE_W];
            a_src_sel       = in_a_source_i[SRC_W*i +: SRC_W];
            out_a_address_o = in_a_address_i[ADDR_W*i +: ADDR_W];
            out_a_mask_o    = in_a_mask_i[MASK_W*i +: MASK_W];
            out_a_data_o    = in_a_data_i[DATA_W*i +: DATA_W];
            out_a_corrupt_o = in_a_corrupt_i[i];
            in_a_ready_o[i] = out_a_ready_i & act_valid & ~rst_i;
         end
      end
   end

   assign out_a_valid_o  = act_valid & ~rst_i;
   assign out_a_source_o = {act_idx, a_src_sel};
   assign a_fire         = out_a_valid_o & out_a_ready_i;

   // Burst length minus one, derived from the first beat; only data-carrying opcodes burst.
   always_comb begin
      first_beats_m1 = '0;
      if (out_a_opcode_o < 3'd4 && out_a_size_o > SIZE_W'(LOG_BYTES)) begin
         first_beats_m1 = ((SIZE_W+1)'(1) << (out_a_size_o - SIZE_W'(LOG_BYTES)))
                          - (SIZE_W+1)'(1);
      end
   end

   // Arbitration FSM: IDLE picks a winner each cycle, LOCKED holds it until the last beat.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         beat_cnt_q   <= '0;
         last_grant_q <= IDX_W'(N_IN - 1);
         grant_idx_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (a_fire) begin
                  if (first_beats_m1 != '0) begin
                     state_q     <= StLocked;
                     grant_idx_q <= win_idx;
                     beat_cnt_q  <= first_beats_m1;
                  end else begin
                     last_grant_q <= win_idx;
                  end
               end
            end
            StLocked: begin
               if (a_fire) begin
                  beat_cnt_q <= beat_cnt_q - 1'b1;
                  if (beat_cnt_q == (SIZE_W+1)'(1)) begin
                     state_q      <= StIdle;
                     last_grant_q <= grant_idx_q;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign d_sel    = out_d_source_i[SRC_W +: IDX_W];
   assign d_sel_ok = {1'b0, d_sel} < (IDX_W+1)'(N_IN);

   // D steering; an out-of-range index is acknowledged and dropped.
   always_comb begin
      in_d_valid_o  = '0;
      out_d_ready_o = ~rst_i & ~d_sel_ok;
      for (int i = 0; i < int'(N_IN); i++) begin
         if (d_sel_ok && d_sel == IDX_W'(i)) begin
            in_d_valid_o[i] = out_d_valid_i & ~rst_i;
            out_d_ready_o   = in_d_ready_i[i] & ~rst_i;
         end
      end
   end

   assign in_d_opcode_o  = {N_IN{out_d_opcode_i}};
   assign in_d_param_o   = {N_IN{out_d_param_i}};
   assign in_d_size_o    = {N_IN{out_d_size_i}};
   assign in_d_source_o  = {N_IN{out_d_source_i[SRC_W-1:0]}};
   assign in_d_sink_o    = {N_IN{out_d_sink_i}};
   assign in_d_denied_o  = {N_IN{out_d_denied_i}};
   assign in_d_data_o    = {N_IN{out_d_data_i}};
   assign in_d_corrupt_o = {N_IN{out_d_corrupt_i}};

endmodule
